cp0_int_unit: RTL
=================

// Module: cp0_int_unit
// PURPOSE
//   Coprocessor-0 receiving end of the external-interrupt handshake. Samples HWInt lines raised by
//   timers and the interrupt generator at 0x7f20. Arbitrates them against synchronous exceptions
//   at the M-stage macroscopic PC. Holds SR/Cause/EPC and drives the flush/redirect request to the pipeline.
//   Software acknowledges the source with a store to 0x7f20, which drops HWInt.
// PARAMETERS
//   HANDLER_ADDR  32'h0000_4180  redirect target driven on handler_pc while req is high
//   HW_INT_W      6              number of external interrupt lines (maps to IP/IM bits 15:10)
// PORTS
//   clk          in   1   rising-edge clock
//   reset        in   1   asynchronous, active-low reset (0 = reset)
//   en           in   1   mtc0 write strobe (M stage)
//   cp0_addr     in   5   CP0 register number for mfc0/mtc0
//   cp0_wdata    in   32  mtc0 data
//   cp0_rdata    out  32  mfc0 data, combinational
//   vpc          in   32  macroscopic PC of the M-stage instruction
//   bd_in        in   1   M-stage instruction sits in a delay slot
//   exc_code_in  in   5   M-stage exception code, 0 = none
//   eret         in   1   eret in M stage
//   hw_int       in   6   external interrupt lines, level-sensitive
//   req          out  1   take exception/interrupt this cycle (flush + redirect)
//   handler_pc   out  32  HANDLER_ADDR
//   epc_out      out  32  current EPC value (eret target)
//   exl          out  1   SR.EXL
// BEHAVIOUR
//   - Registers: SR(12): IM[15:10], EXL[1], IE[0]. Cause(13): BD[31], IP[15:10], ExcCode[6:2].
//     EPC(14): 32-bit. PRId(15): constant 32'h2023_0007. Every other field and address reads 0.
//   - Reset (reset=0, async): SR, Cause and EPC all 0. Outputs then: req=0, exl=0, epc_out=0, cp0_rdata per addr.
//   - IP <= hw_int every clock edge, unconditionally (raw mirror; no latching, no edge detect).
//   - int_req = |(hw_int & SR.IM) & SR.IE & !SR.EXL. The current hw_int is used, not IP.
//     Interrupt latency is therefore 0 cycles from hw_int to req.
//   - exc_req = (exc_code_in != 0) & !SR.EXL.  req = int_req | exc_req (combinational).
//   - On a posedge with req=1:
//     EXL<=1; ExcCode <= int_req ? 0 : exc_code_in (interrupt wins); BD<=bd_in;
//     EPC <= bd_in ? {vpc[31:2],2'b0}-4 : {vpc[31:2],2'b0}.
//   - On a posedge with eret=1 and req=0: EXL<=0. A req in the same cycle overrides eret.
//     eret itself never raises req.
//   - mtc0 (en=1) writes only SR (IM, EXL, IE bits) and EPC. Cause is read-only.
//     The write takes effect at the edge and is suppressed when req=1 in the same cycle.
//   - mfc0 reads registered state and does not bypass a same-cycle mtc0.
//     epc_out reflects EPC after the edge (pipeline stalls eret behind mtc0 EPC).
//   - EXL=1 masks both interrupts and further exceptions. An exception under EXL is ignored (req=0).
//   - If hw_int stays high after eret, req re-asserts as soon as EXL clears (next instruction).
//     This is the required behaviour when software has not acknowledged at 0x7f20.
//   - Reset mid-exception: all state clears immediately; req drops asynchronously with EXL/IE.
//   - Widths: EPC arithmetic is 32-bit modulo. vpc=0 with bd_in gives 32'hffff_fffc (no saturation).
// STRUCTURE
//   - Shared package: CP0 register numbers (SR=12, CAUSE=13, EPC=14, PRID=15).
//   - Shared package also holds the ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12),
//     HANDLER_ADDR, and the interrupt-generator address 32'h0000_7f20.
//   - Single module; the priority/arbitration logic may be split into sub-module cp0_arbiter
//     (pure combinational: req, is_int, next ExcCode).
// TESTING
//   1. reset=0 then 1 -> SR=Cause=EPC=0, req=0; mfc0 $12/$13/$14 read 0; mfc0 $15 reads 32'h2023_0007.
//   2. mtc0 SR=32'h0000_fc01, hw_int[2]=1 at vpc=32'h3010, bd_in=0
//      -> req=1 the same cycle; after edge EPC=32'h3010, ExcCode=0, EXL=1, Cause.IP=6'b000100.
//   3. Same as 2 with bd_in=1 -> EPC=32'h300c, Cause.BD=1.
//   4. Simultaneous hw_int[0]=1 and exc_code_in=12 -> ExcCode=0 (interrupt wins).
//      Repeat with IE=0 -> ExcCode=12, EPC=vpc.
//   5. EXL=1, exc_code_in=4 -> req=0 and no state change.
//      eret -> EXL=0 next edge; a held hw_int re-raises req the following cycle.
//   6. mtc0 EPC=32'h4000 with req=1 in the same cycle -> write dropped, EPC=vpc.
//      Async reset asserted mid-cycle while EXL=1 -> exl=0 and req=0 before the next edge.

Source files
------------

// File: rtl/cp0_int_unit_pkg.sv
// Shared CP0 definitions for the interrupt unit.
//   - CP0 register numbers for mfc0/mtc0 (SR, Cause, EPC, PRId)
//   - ExcCode constants written into Cause[6:2]
//   - Fixed addresses: exception handler entry and the interrupt generator
//   - epc_target(): the address EPC records for an instruction at vpc
package cp0_int_unit_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_4180;
  localparam logic [31:0] INT_GEN_ADDR     = 32'h0000_7f20;
  localparam logic [31:0] PRID_VALUE       = 32'h2023_0007;

  // IM (in SR) and IP (in Cause) both start at bit 10.
  localparam int unsigned IM_LSB = 10;

  // A delay-slot instruction is restarted from its branch, one word earlier.
  // Subtraction wraps modulo 2^32 on purpose (vpc=0 gives 32'hffff_fffc).
  function automatic logic [31:0] epc_target(input logic [31:0] vpc, input logic bd);
    logic [31:0] aligned;
    aligned = {vpc[31:2], 2'b00};
    return bd ? aligned - 32'd4 : aligned;
  endfunction

endpackage

// File: rtl/cp0_int_unit_arbiter.sv
// cp0_arbiter: combinational priority between external interrupts and the
// synchronous exception of the M-stage instruction.
//   hw_int       in   live interrupt lines (not the registered IP copy)
//   im, ie, exl  in   SR mask / enable / exception-level bits
//   exc_code_in  in   M-stage exception code, 0 = none
//   req          out  take an interrupt or exception this cycle
//   is_int       out  the interrupt is the winner
//   exc_code_nxt out  ExcCode to record when req is taken
module cp0_arbiter
  import cp0_int_unit_pkg::*;
#(
  parameter int unsigned HW_INT_W = 6
) (
  input  logic [HW_INT_W-1:0] hw_int,
  input  logic [HW_INT_W-1:0] im,
  input  logic                ie,
  input  logic                exl,
  input  logic [4:0]          exc_code_in,
  output logic                req,
  output logic                is_int,
  output logic [4:0]          exc_code_nxt
);

  logic exc_req;

  // EXL masks both sources, so a nested exception is silently dropped.
  assign is_int       = (|(hw_int & im)) & ie & ~exl;
  assign exc_req      = (exc_code_in != EXC_INT) & ~exl;
  assign req          = is_int | exc_req;
  assign exc_code_nxt = is_int ? EXC_INT : exc_code_in;

endmodule

// File: rtl/cp0_int_unit.sv
// cp0_int_unit: CP0 receiving end of the external-interrupt handshake.
// Holds SR/Cause/EPC, arbitrates hw_int against M-stage exceptions and
// requests a flush + redirect to handler_pc.
//   clk, reset   rising-edge clock; asynchronous active-low reset
//   en, cp0_addr, cp0_wdata   mtc0 write port (SR and EPC only)
//   cp0_rdata    mfc0 read of registered state, combinational
//   vpc, bd_in, exc_code_in, eret   M-stage instruction info
//   hw_int       level-sensitive external interrupt lines
//   req          take exception/interrupt this cycle
//   handler_pc   constant handler entry address
//   epc_out, exl current EPC and SR.EXL
module cp0_int_unit
  import cp0_int_unit_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF,
  parameter int unsigned HW_INT_W     = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [4:0]          cp0_addr,
  input  logic [31:0]         cp0_wdata,
  output logic [31:0]         cp0_rdata,
  input  logic [31:0]         vpc,
  input  logic                bd_in,
  input  logic [4:0]          exc_code_in,
  input  logic                eret,
  input  logic [HW_INT_W-1:0] hw_int,
  output logic                req,
  output logic [31:0]         handler_pc,
  output logic [31:0]         epc_out,
  output logic                exl
);

  logic [HW_INT_W-1:0] sr_im_q, sr_im_d;
  logic                sr_exl_q, sr_exl_d;
  logic                sr_ie_q, sr_ie_d;
  logic                cause_bd_q, cause_bd_d;
  logic [HW_INT_W-1:0] cause_ip_q, cause_ip_d;
  logic [4:0]          cause_exc_q, cause_exc_d;
  logic [31:0]         epc_q, epc_d;

  logic                is_int;
  logic [4:0]          exc_code_nxt;

  cp0_arbiter #(.HW_INT_W(HW_INT_W)) u_arbiter (
    .hw_int       (hw_int),
    .im           (sr_im_q),
    .ie           (sr_ie_q),
    .exl          (sr_exl_q),
    .exc_code_in  (exc_code_in),
    .req          (req),
    .is_int       (is_int),
    .exc_code_nxt (exc_code_nxt)
  );

  always_comb begin
    // NOTE: every _d starts as its _q; without these defaults any path that
    // skips an assignment would infer a latch.
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    // IP is a raw mirror of the lines; acknowledge happens at the source.
    cause_ip_d  = hw_int;

    if (req) begin
      // Taking an exception overrides both eret and a same-cycle mtc0.
      sr_exl_d    = 1'b1;
      cause_exc_d = exc_code_nxt;
      cause_bd_d  = bd_in;
      epc_d       = epc_target(vpc, bd_in);
    end else begin
      if (eret) sr_exl_d = 1'b0;
      if (en) begin
        unique case (cp0_addr)
          CP0_SR: begin
            sr_im_d  = cp0_wdata[IM_LSB +: HW_INT_W];
            sr_exl_d = cp0_wdata[1];
            sr_ie_d  = cp0_wdata[0];
          end
          CP0_EPC: epc_d = cp0_wdata;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_im_q     <= '0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= '0;
      cause_exc_q <= '0;
      epc_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before the edge, independent of statement order.
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  // mfc0 sees registered state only; a same-cycle mtc0 is not forwarded.
  always_comb begin
    cp0_rdata = '0;
    unique case (cp0_addr)
      CP0_SR: begin
        cp0_rdata[IM_LSB +: HW_INT_W] = sr_im_q;
        cp0_rdata[1]                  = sr_exl_q;
        cp0_rdata[0]                  = sr_ie_q;
      end
      CP0_CAUSE: begin
        cp0_rdata[31]                 = cause_bd_q;
        cp0_rdata[IM_LSB +: HW_INT_W] = cause_ip_q;
        cp0_rdata[6:2]                = cause_exc_q;
      end
      CP0_EPC:  cp0_rdata = epc_q;
      CP0_PRID: cp0_rdata = PRID_VALUE;
      default:  ;
    endcase
  end

  assign handler_pc = HANDLER_ADDR;
  assign epc_out    = epc_q;
  assign exl        = sr_exl_q;

endmodule
